// File: rtl/sram_2048x8.sv
// 2048x8 synchronous-read SRAM on a shared tri-state bus, built from 16 column banks of 128 words.
// The low address nibble picks the bank and the upper 7 bits pick the row within it.
module sram_bank #(
    parameter int WORD_SIZE     = 8,
    parameter int MEM_DEPTH     = 128,
    parameter int ROW_ADDR_SIZE = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [ROW_ADDR_SIZE-1:0] row,
    input  logic [WORD_SIZE-1:0]     wdata,
    output logic [WORD_SIZE-1:0]     rdata
);
    // No reset on the array: contents survive rst_n.
    logic [WORD_SIZE-1:0] mem_q [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem_q[row] <= wdata;
    end

    assign rdata = mem_q[row];
endmodule

module sram_2048x8 #(
    parameter int WORD_SIZE     = 8,
    parameter int ADDR_SIZE     = 11,
    parameter int MEM_DEPTH     = 128,
    parameter int NUM_COL       = 16,
    parameter int COL_ADDR_SIZE = 4,
    parameter int ROW_ADDR_SIZE = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inout  wire  [WORD_SIZE-1:0] data_bus,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 CS_b,
    input  logic                 OE_b,
    input  logic                 WE_b
);
    logic [COL_ADDR_SIZE-1:0]              col_addr;
    logic [ROW_ADDR_SIZE-1:0]              row_addr;
    logic                                  wr_en;
    logic                                  rd_oe;
    logic [NUM_COL-1:0][WORD_SIZE-1:0]     bank_rd;
    logic [WORD_SIZE-1:0]                  rd_d;
    logic [WORD_SIZE-1:0]                  rd_q;

    assign col_addr = addr[COL_ADDR_SIZE-1:0];
    assign row_addr = addr[ADDR_SIZE-1:COL_ADDR_SIZE];

    // Write wins over OE_b; holding rst_n low also blocks writes.
    assign wr_en = !CS_b && !WE_b && rst_n;
    assign rd_oe = !CS_b && WE_b && !OE_b;

    for (genvar c = 0; c < NUM_COL; c++) begin : col
        sram_bank #(
            .WORD_SIZE    (WORD_SIZE),
            .MEM_DEPTH    (MEM_DEPTH),
            .ROW_ADDR_SIZE(ROW_ADDR_SIZE)
        ) u_bank (
            .clk  (clk),
            .we   (wr_en && (col_addr == COL_ADDR_SIZE'(c))),
            .row  (row_addr),
            .wdata(data_bus),
            .rdata(bank_rd[c])
        );
    end

    always_comb begin
        rd_d = bank_rd[col_addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_q <= '0;
        else        rd_q <= rd_d;
    end

    assign data_bus = rd_oe ? rd_q : {WORD_SIZE{1'bz}};
endmodule

// File: tb/tb_sram_2048x8.sv
// Scoreboarded bench for sram_2048x8: walking-ones sweep, random traffic, bus release,
// write priority, reset retention and bank independence against an array model.
module tb_sram_2048x8;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] addr = '0;
    logic        CS_b = 1'b1;
    logic        OE_b = 1'b1;
    logic        WE_b = 1'b1;
    logic        drv_en = 1'b0;
    logic [7:0]  drv_val = '0;
    wire  [7:0]  data_bus;

    assign data_bus = drv_en ? drv_val : 8'bz;

    sram_2048x8 dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_bus(data_bus),
        .addr    (addr),
        .CS_b    (CS_b),
        .OE_b    (OE_b),
        .WE_b    (WE_b)
    );

    always #5 clk = ~clk;

    logic [7:0]  model [2048];
    logic [7:0]  exp_q [$];
    logic [10:0] tag_q [$];
    logic        rd_req = 1'b0;
    logic        pend = 1'b0;
    int          passed = 0;
    int          total = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %02h expected %02h", name, act, exp);
    endtask

    // Monitor: a read issued in cycle k is on the bus after the following edge.
    always @(posedge clk) pend <= rd_req;

    always @(negedge clk) begin
        if (pend) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL read_unexpected: got %02h expected none", data_bus);
            end else begin
                logic [7:0]  e;
                logic [10:0] t;
                e = exp_q.pop_front();
                t = tag_q.pop_front();
                check($sformatf("read_addr_%03h", t), data_bus, e);
            end
        end
    end

    task automatic do_write(input logic [10:0] a, input logic [7:0] d);
        @(posedge clk); #1;
        rd_req = 1'b0; addr = a; drv_val = d; drv_en = 1'b1;
        CS_b = 1'b0; WE_b = 1'b0; OE_b = 1'b1;
        model[a] = d;
    endtask

    task automatic do_read(input logic [10:0] a);
        @(posedge clk); #1;
        drv_en = 1'b0; addr = a; CS_b = 1'b0; WE_b = 1'b1; OE_b = 1'b0;
        rd_req = 1'b1;
        exp_q.push_back(model[a]);
        tag_q.push_back(a);
    endtask

    // Hold read mode one more cycle so the last queued read is observed.
    task automatic flush();
        @(posedge clk); #1;
        rd_req = 1'b0;
    endtask

    function automatic logic [7:0] walk(input logic [10:0] a);
        return 8'h01 << (a[10:4] % 8);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state: rd_q cleared, bus driven only in read mode.
        CS_b = 1'b0; WE_b = 1'b1; OE_b = 1'b0;
        #12;
        check("reset_bus_zero", data_bus, 8'h00);
        CS_b = 1'b1; drv_en = 1'b1; drv_val = 8'h3C; #1;
        check("reset_deselect_release", data_bus, 8'h3C);
        drv_en = 1'b0;
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 2048; i++) do_write(11'(i), walk(11'(i)));
        @(posedge clk); #1;
        CS_b = 1'b1; WE_b = 1'b1; drv_en = 1'b0;
        check("probe_col5_row1", dut.col[5].u_bank.mem_q[1], 8'h02);
        check("probe_col15_row7", dut.col[15].u_bank.mem_q[7], 8'h80);

        for (int i = 0; i < 2048; i++) do_read(11'(i));
        flush();

        // Reset mid-read of a word holding 8'h40 (row 6, col 2).
        @(posedge clk); #1;
        addr = 11'h062; CS_b = 1'b0; WE_b = 1'b1; OE_b = 1'b0;
        @(posedge clk); #1;
        check("pre_reset_read", data_bus, 8'h40);
        rst_n = 1'b0; #1;
        check("reset_immediate_zero", data_bus, 8'h00);
        @(posedge clk); #1;
        WE_b = 1'b0; drv_en = 1'b1; drv_val = 8'hEE;
        @(posedge clk); #1;
        WE_b = 1'b1; drv_en = 1'b0; #1;
        check("reset_hold_zero", data_bus, 8'h00);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_retain", data_bus, 8'h40);

        // Bus release while rd_q holds 8'h40; bench value must survive.
        drv_val = 8'h0F;
        CS_b = 1'b1; drv_en = 1'b1; #1;
        check("release_cs", data_bus, 8'h0F);
        CS_b = 1'b0; OE_b = 1'b1; #1;
        check("release_oe", data_bus, 8'h0F);
        OE_b = 1'b0; WE_b = 1'b0; #1;
        check("release_we", data_bus, 8'h0F);
        model[11'h062] = 8'h0F;
        @(posedge clk); #1;
        WE_b = 1'b1; drv_en = 1'b0; CS_b = 1'b1;

        // Write priority: OE_b low during a write must not turn the bus around.
        @(posedge clk); #1;
        addr = 11'h000; drv_en = 1'b1; drv_val = 8'hA5;
        CS_b = 1'b0; WE_b = 1'b0; OE_b = 1'b0; #1;
        check("write_priority_bus", data_bus, 8'hA5);
        model[11'h000] = 8'hA5;
        do_read(11'h000);
        do_read(11'h062);
        flush();

        // Bank independence at row 3.
        do_write(11'h030, 8'hFF);
        do_write(11'h031, 8'h00);
        for (int c = 0; c < 16; c++) do_read({7'd3, 4'(c)});
        flush();

        // Random traffic against the model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 40; i++)
                do_write(11'($urandom_range(0, 2047)), 8'($urandom));
            for (int i = 0; i < 40; i++)
                do_read(11'($urandom_range(0, 2047)));
            flush();
        end

        @(posedge clk); #1;
        CS_b = 1'b1;
        repeat (3) @(posedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
